// File: rtl/sw_tracker_pkg.sv
// Shared types for the Smith-Waterman result tracker: FSM states and the
// per-query summary entry layout at the default bus widths.
package sw_tracker_pkg;

    localparam int DEF_CALC_W = 16;
    localparam int DEF_TIDX_W = 8;
    localparam int DEF_QIDX_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DELAY,
        S_START,
        S_RUN,
        S_DONE,
        S_TOUT
    } state_t;

    // Field order matches the flat word carried through the summary FIFO.
    typedef struct packed {
        logic [DEF_QIDX_W-1:0] q;
        logic [DEF_TIDX_W-1:0] t;
        logic [DEF_CALC_W-1:0] score;
        logic                  err;
    } sum_entry_t;

endpackage

// File: rtl/sw_summary_fifo.sv
// Synchronous FIFO for per-query summaries; full-and-popping accepts a push,
// a push while full without a pop is dropped and flagged for one cycle.
module sw_summary_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic             drop
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic [AW:0]      count_next;
    logic             empty_reg;
    logic             full_reg;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty_reg;
    assign do_push = push && (!full_reg || do_pop);
    assign drop    = push && full_reg && !do_pop;

    always_comb begin
        count_next = count_reg;
        case ({do_push, do_pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            empty_reg  <= 1'b1;
            full_reg   <= 1'b0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_next;
            empty_reg <= (count_next == '0);
            full_reg  <= (count_next == (AW+1)'(DEPTH));
        end
    end

    // Stale storage is masked so the outputs read zero whenever nothing is held.
    assign dout  = empty_reg ? '0 : mem[rd_ptr_reg];
    assign empty = empty_reg;
    assign full  = full_reg;

endmodule

// File: rtl/sw_result_tracker.sv
// Host-side sequencer/scoreboard for the Smith-Waterman core.
// Optional core cross-check of the reported best match: define SW_CHECK_EN.
module sw_result_tracker
    import sw_tracker_pkg::*;
#(
    parameter int CALC_W      = DEF_CALC_W,
    parameter int TIDX_W      = DEF_TIDX_W,
    parameter int QIDX_W      = DEF_QIDX_W,
    parameter int FIFO_DEPTH  = 4,
    parameter int START_DELAY = 5,
    parameter int TIMEOUT     = 50000,
    parameter int TMO_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arm_i,
    output logic              start_o,
    input  logic              busy_i,
    input  logic              valid_i,
    input  logic [CALC_W-1:0] result_i,
    input  logic              change_q_i,
    input  logic [TIDX_W-1:0] match_idx_i,
    input  logic [CALC_W-1:0] max_result_i,
    output logic [TIDX_W-1:0] t_idx_o,
    output logic [QIDX_W-1:0] q_idx_o,
    output logic              sum_valid_o,
    input  logic              sum_ready_i,
    output logic [QIDX_W-1:0] sum_q_o,
    output logic [TIDX_W-1:0] sum_t_o,
    output logic [CALC_W-1:0] sum_score_o,
    output logic              sum_err_o,
    output logic              done_o,
    output logic              timeout_o,
    output logic              ovf_o
);
    localparam int ENTRY_W = QIDX_W + TIDX_W + CALC_W + 1;
    localparam int DLY_W   = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;

    state_t            state_reg;
    logic [DLY_W-1:0]  dly_cnt_reg;
    logic [TMO_W-1:0]  tmo_cnt_reg;
    logic              start_reg, done_reg, timeout_reg, ovf_reg;
    logic [TIDX_W-1:0] t_idx_reg, best_t_reg, best_t_next;
    logic [QIDX_W-1:0] q_idx_reg;
    logic [CALC_W-1:0] best_score_reg, best_score_next;
    logic              first_reg;
    logic              accept, take, err_next, push, pop, tmo_hit, dly_last;
    logic [ENTRY_W-1:0] fifo_din, fifo_dout;
    logic              fifo_empty, fifo_drop, fifo_err, fifo_full_unused;

    assign accept   = valid_i && (state_reg == S_RUN);
    assign tmo_hit  = (tmo_cnt_reg == TMO_W'(TIMEOUT - 1));
    assign dly_last = (dly_cnt_reg == DLY_W'(START_DELAY - 1));

    // First result of a query always loads; later ones must be strictly larger.
    assign take            = first_reg || (result_i > best_score_reg);
    assign best_t_next     = take ? t_idx_reg : best_t_reg;
    assign best_score_next = take ? result_i  : best_score_reg;

`ifdef SW_CHECK_EN
    assign err_next  = (match_idx_i != best_t_next) || (max_result_i != best_score_next);
    assign sum_err_o = fifo_err;
`else
    logic core_best_unused;
    assign core_best_unused = ^{match_idx_i, max_result_i, fifo_err};
    assign err_next  = 1'b0;
    assign sum_err_o = 1'b0;
`endif

    assign push     = accept && change_q_i;
    assign pop      = sum_valid_o && sum_ready_i;
    assign fifo_din = {q_idx_reg, best_t_next, best_score_next, err_next};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            dly_cnt_reg    <= '0;
            tmo_cnt_reg    <= '0;
            start_reg      <= 1'b0;
            done_reg       <= 1'b0;
            timeout_reg    <= 1'b0;
            ovf_reg        <= 1'b0;
            t_idx_reg      <= '0;
            q_idx_reg      <= '0;
            best_t_reg     <= '0;
            best_score_reg <= '0;
            first_reg      <= 1'b1;
        end else begin
            start_reg <= 1'b0;
            case (state_reg)
                S_IDLE, S_DONE, S_TOUT: begin
                    if (arm_i) begin
                        state_reg      <= S_DELAY;
                        done_reg       <= 1'b0;
                        timeout_reg    <= 1'b0;
                        ovf_reg        <= 1'b0;
                        t_idx_reg      <= '0;
                        q_idx_reg      <= '0;
                        tmo_cnt_reg    <= '0;
                        dly_cnt_reg    <= '0;
                        best_t_reg     <= '0;
                        best_score_reg <= '0;
                        first_reg      <= 1'b1;
                    end
                end
                S_DELAY: begin
                    if (tmo_hit) begin
                        state_reg   <= S_TOUT;
                        timeout_reg <= 1'b1;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
                        if (dly_last) state_reg <= S_START;
                        else          dly_cnt_reg <= dly_cnt_reg + 1'b1;
                    end
                end
                S_START: begin
                    if (tmo_hit) begin
                        state_reg   <= S_TOUT;
                        timeout_reg <= 1'b1;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
                        start_reg   <= 1'b1;
                        state_reg   <= S_RUN;
                    end
                end
                S_RUN: begin
                    // busy_i is ignored while the start pulse is still on the wire.
                    if (!start_reg && !busy_i) begin
                        state_reg <= S_DONE;
                        done_reg  <= 1'b1;
                    end else if (tmo_hit) begin
                        state_reg   <= S_TOUT;
                        timeout_reg <= 1'b1;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase

            if (accept) begin
                if (change_q_i) begin
                    t_idx_reg      <= '0;
                    q_idx_reg      <= q_idx_reg + 1'b1;
                    best_t_reg     <= '0;
                    best_score_reg <= '0;
                    first_reg      <= 1'b1;
                end else begin
                    t_idx_reg      <= t_idx_reg + 1'b1;
                    best_t_reg     <= best_t_next;
                    best_score_reg <= best_score_next;
                    first_reg      <= 1'b0;
                end
            end

            if (fifo_drop) ovf_reg <= 1'b1;
        end
    end

    sw_summary_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .srst  (rst),
        .push  (push),
        .pop   (pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full_unused),
        .drop  (fifo_drop)
    );

    assign {sum_q_o, sum_t_o, sum_score_o, fifo_err} = fifo_dout;
    assign sum_valid_o = !fifo_empty;
    assign start_o     = start_reg;
    assign done_o      = done_reg;
    assign timeout_o   = timeout_reg;
    assign ovf_o       = ovf_reg;
    assign t_idx_o     = t_idx_reg;
    assign q_idx_o     = q_idx_reg;

endmodule

// File: tb/tb_sw_result_tracker.sv
// Scoreboard bench for sw_result_tracker: stimulus pushes expected summaries,
// a negedge monitor pops and compares every summary the DUT hands out.
module tb_sw_result_tracker;
`ifdef SW_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    logic        clk = 1'b0, rst = 1'b1, arm_i = 1'b0, busy_i = 1'b0;
    logic        valid_i = 1'b0, change_q_i = 1'b0, sum_ready_i = 1'b0;
    logic [15:0] result_i = '0, max_result_i = '0;
    logic [7:0]  match_idx_i = '0;
    logic        start_o, sum_valid_o, sum_err_o, done_o, timeout_o, ovf_o;
    logic [7:0]  t_idx_o, q_idx_o, sum_q_o, sum_t_o;
    logic [15:0] sum_score_o;

    int n_checks = 0, n_pass = 0, done_rises = 0;
    logic done_prev = 1'b0;
    logic [32:0] exp_q[$];

    sw_result_tracker #(
        .CALC_W(16), .TIDX_W(8), .QIDX_W(8), .FIFO_DEPTH(4),
        .START_DELAY(5), .TIMEOUT(100), .TMO_W(16)
    ) dut (
        .clk(clk), .rst(rst), .arm_i(arm_i), .start_o(start_o), .busy_i(busy_i),
        .valid_i(valid_i), .result_i(result_i), .change_q_i(change_q_i),
        .match_idx_i(match_idx_i), .max_result_i(max_result_i),
        .t_idx_o(t_idx_o), .q_idx_o(q_idx_o), .sum_valid_o(sum_valid_o),
        .sum_ready_i(sum_ready_i), .sum_q_o(sum_q_o), .sum_t_o(sum_t_o),
        .sum_score_o(sum_score_o), .sum_err_o(sum_err_o), .done_o(done_o),
        .timeout_o(timeout_o), .ovf_o(ovf_o)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic expect_sum(input int q, input int t, input int score, input logic err);
        exp_q.push_back({8'(q), 8'(t), 16'(score), err});
    endtask

    task automatic send(input int r, input logic chg, input int midx, input int mres);
        valid_i = 1'b1; result_i = 16'(r); change_q_i = chg;
        match_idx_i = 8'(midx); max_result_i = 16'(mres);
        tick;
        valid_i = 1'b0; change_q_i = 1'b0;
    endtask

    task automatic do_arm(output int lat);
        arm_i = 1'b1;
        tick;
        arm_i = 1'b0;
        lat = 0;
        while (!start_o && lat < 20) begin
            tick;
            lat++;
        end
    endtask

    task automatic finish_run;
        int n = 0;
        busy_i = 1'b0;
        while (!done_o && n < 10) begin
            tick;
            n++;
        end
        chk("done_set", done_o, 1);
    endtask

    always @(negedge clk) begin
        if (done_o && !done_prev) done_rises++;
        done_prev = done_o;
    end

    // Monitor: every handshake on the summary port consumes one expectation.
    always @(negedge clk) begin
        if (!rst && sum_valid_o && sum_ready_i) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL summary_unexpected: got q=%0d t=%0d score=%0d, expected none",
                         sum_q_o, sum_t_o, sum_score_o);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                chk("summary", {sum_q_o, sum_t_o, sum_score_o, sum_err_o}, e);
                $display("summary q=%0d t=%0d score=%0d err=%0d", sum_q_o, sum_t_o, sum_score_o, sum_err_o);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200us");
        $fatal(1);
    end

    initial begin
        int lat;
        int n;
        repeat (3) tick;
        chk("reset_outputs", {start_o, t_idx_o, q_idx_o, sum_valid_o, sum_q_o, sum_t_o,
                              sum_score_o, sum_err_o, done_o, timeout_o, ovf_o}, 0);
        rst = 1'b0;
        tick;

        // 1: start timing and completion
        do_arm(lat);
        chk("start_latency", lat, 6);
        busy_i = 1'b1;
        tick;
        chk("start_one_cycle", start_o, 0);
        repeat (19) tick;
        finish_run;
        chk("no_timeout", timeout_o, 0);
        tick;
        chk("done_rises", done_rises, 1);

        // 2 and 3: best tracking, tie, single-result and unsigned queries
        sum_ready_i = 1'b1;
        do_arm(lat);
        busy_i = 1'b1;
        send(3, 0, 0, 0); send(9, 0, 0, 0); send(9, 0, 0, 0);
        chk("t_idx_mid", t_idx_o, 3);
        expect_sum(0, 1, 9, 1'b0);
        send(2, 1, 1, 9);
        chk("t_idx_wrap", t_idx_o, 0);
        chk("q_idx_inc", q_idx_o, 1);
        send(3, 0, 0, 0); send(9, 0, 0, 0); send(9, 0, 0, 0);
        expect_sum(1, 1, 9, CHK);
        send(2, 1, 2, 9);
        expect_sum(2, 0, 0, 1'b0);
        send(0, 1, 0, 0);
        expect_sum(3, 1, 16'h8000, 1'b0);
        send(16'h7fff, 0, 0, 0);
        send(16'h8000, 1, 1, 16'h8000);
        finish_run;
        chk("q_idx_end", q_idx_o, 4);
        send(7, 1, 0, 0);
        chk("ignore_outside_run", q_idx_o, 4);
        repeat (3) tick;
        chk("fifo_drained_t3", sum_valid_o, 0);

        // 4: overflow with consumer stalled, then ordered drain
        sum_ready_i = 1'b0;
        do_arm(lat);
        busy_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k < 4) expect_sum(k, 0, 10 + k, 1'b0);
            else chk("ovf_before", ovf_o, 0);
            send(10 + k, 0, 0, 0);
            send(5, 1, 0, 10 + k);
        end
        chk("ovf_set", ovf_o, 1);
        chk("fifo_head_q", sum_q_o, 0);
        sum_ready_i = 1'b1;
        n = 0;
        while (sum_valid_o && n < 20) begin
            tick;
            n++;
        end
        chk("fifo_empty_after_drain", sum_valid_o, 0);
        chk("sb_all_drained", exp_q.size(), 0);
        finish_run;

        // 5: timeout
        arm_i = 1'b1;
        tick;
        arm_i = 1'b0;
        busy_i = 1'b1;
        n = 0;
        while (!timeout_o && n < 200) begin
            tick;
            n++;
        end
        chk("timeout_latency", n, 100);
        chk("timeout_no_done", done_o, 0);
        do_arm(lat);
        chk("rearm_start_latency", lat, 6);
        chk("rearm_clears_timeout", timeout_o, 0);

        // 6: reset mid-run with queued summaries
        sum_ready_i = 1'b0;
        send(1, 1, 0, 1);
        send(2, 1, 0, 2);
        chk("queued_before_rst", sum_valid_o, 1);
        rst = 1'b1;
        tick;
        chk("midrun_reset_outputs", {start_o, t_idx_o, q_idx_o, sum_valid_o, sum_q_o, sum_t_o,
                                     sum_score_o, sum_err_o, done_o, timeout_o, ovf_o}, 0);
        rst = 1'b0;
        busy_i = 1'b0;
        sum_ready_i = 1'b1;
        tick;
        do_arm(lat);
        chk("post_rst_start_latency", lat, 6);
        busy_i = 1'b1;
        expect_sum(0, 0, 42, 1'b0);
        send(42, 1, 0, 42);
        finish_run;
        repeat (3) tick;
        chk("sb_final_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
